// File: rtl/pos_cell_reader.sv
// Streams one cell of particle positions: reads the count word at address 0,
// then words 1..count through a 2-cycle-latency memory into a 4-entry output FIFO.
module pos_cell_reader #(
  parameter int DATA_WIDTH   = 96,
  parameter int ADDR_WIDTH   = 8,
  parameter int PARTICLE_NUM = 220
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_rden,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic [DATA_WIDTH-1:0] out_pos,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  out_last,
  output logic [ADDR_WIDTH-1:0] particle_count,
  output logic                  busy,
  output logic                  done,
  output logic                  count_err
);

  typedef enum logic [2:0] {IDLE, CNT_REQ, CNT_WAIT, STREAM, DRAIN, FIN} state_t;

  localparam logic [ADDR_WIDTH-1:0] C_MAX = ADDR_WIDTH'(PARTICLE_NUM - 1);

  state_t                r_state;
  logic                  r_wait;
  logic [ADDR_WIDTH:0]   r_next;
  logic                  r_v1, r_v2;
  logic [ADDR_WIDTH-1:0] r_a1, r_a2;

  logic [DATA_WIDTH-1:0] r_fpos [4];
  logic [ADDR_WIDTH-1:0] r_fidx [4];
  logic [1:0]            r_wr, r_rd;
  logic [2:0]            r_fcnt;

  logic [ADDR_WIDTH-1:0] w_raw, w_clamped;
  logic                  w_over, w_pop, w_push, w_credit, w_issue;
  logic [3:0]            w_occ;

  always_comb begin
    w_raw     = mem_q[ADDR_WIDTH-1:0];
    w_over    = w_raw > C_MAX;
    w_clamped = w_over ? C_MAX : w_raw;
    w_push    = r_v2;
    w_pop     = out_valid & out_ready;
    // Credit counts every read not yet popped; the entry leaving this cycle frees a slot,
    // which is what lets a full-rate stream run with only four slots.
    w_occ     = 4'(mem_rden) + 4'(r_v1) + 4'(r_v2) + 4'(r_fcnt) - 4'(w_pop);
    w_credit  = w_occ < 4'd4;
    w_issue   = (r_state == STREAM) && (r_next <= {1'b0, particle_count}) && w_credit;
  end

  always_comb begin
    out_valid = r_fcnt != 3'd0;
    out_pos   = out_valid ? r_fpos[r_rd] : '0;
    out_index = out_valid ? r_fidx[r_rd] : '0;
    out_last  = out_valid && (r_fidx[r_rd] == particle_count);
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_wait         <= 1'b0;
      r_next         <= '0;
      r_v1           <= 1'b0;
      r_v2           <= 1'b0;
      r_a1           <= '0;
      r_a2           <= '0;
      mem_rden       <= 1'b0;
      mem_address    <= '0;
      particle_count <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      count_err      <= 1'b0;
    end else begin
      mem_rden <= 1'b0;
      done     <= 1'b0;
      // The count read (issued from CNT_REQ) is not tracked as particle data.
      r_v1     <= mem_rden && (r_state != CNT_REQ);
      r_a1     <= mem_address;
      r_v2     <= r_v1;
      r_a2     <= r_a1;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state     <= CNT_REQ;
            busy        <= 1'b1;
            mem_rden    <= 1'b1;
            mem_address <= '0;
            count_err   <= 1'b0;
          end
        end
        CNT_REQ: begin
          r_state <= CNT_WAIT;
          r_wait  <= 1'b0;
        end
        CNT_WAIT: begin
          if (!r_wait) begin
            r_wait <= 1'b1;
          end else begin
            particle_count <= w_clamped;
            if (w_over) count_err <= 1'b1;
            if (w_clamped == '0) begin
              r_state <= FIN;
              done    <= 1'b1;
            end else begin
              // Address 1 is issued on the capture edge so streaming starts with no bubble.
              mem_rden    <= 1'b1;
              mem_address <= ADDR_WIDTH'(1);
              r_next      <= (ADDR_WIDTH+1)'(2);
              r_state     <= (w_clamped == ADDR_WIDTH'(1)) ? DRAIN : STREAM;
            end
          end
        end
        STREAM: begin
          if (w_issue) begin
            mem_rden    <= 1'b1;
            mem_address <= r_next[ADDR_WIDTH-1:0];
            r_next      <= r_next + (ADDR_WIDTH+1)'(1);
            if (r_next == {1'b0, particle_count}) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!mem_rden && !r_v1 && !r_v2 && (r_fcnt == 3'd0)) begin
            r_state <= FIN;
            done    <= 1'b1;
          end
        end
        FIN: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_fcnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 2'd1;
      if (w_pop)  r_rd <= r_rd + 2'd1;
      r_fcnt <= r_fcnt + 3'(w_push) - 3'(w_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fpos[r_wr] <= mem_q;
      r_fidx[r_wr] <= r_a2;
    end
  end

endmodule

// File: tb/tb_pos_cell_reader.sv
// Bench for pos_cell_reader: 2-cycle memory model, randomized contents and
// back-pressure, compared against the expected stream mem[1..min(raw,PN-1)].
module tb_pos_cell_reader;
  localparam int DW = 96;
  localparam int AW = 8;
  localparam int PN = 220;

  logic          clock = 1'b0;
  logic          rst, start, out_ready;
  logic          mem_rden, out_valid, out_last, busy, done, count_err;
  logic [AW-1:0] mem_address, out_index, particle_count;
  logic [DW-1:0] mem_q, out_pos;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] q_d1;
  logic          v_d1;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    v_d1  <= mem_rden;
    q_d1  <= mem[mem_address];
    mem_q <= v_d1 ? q_d1 : {3{32'hBAD0_BAD0}};
  end

  pos_cell_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PARTICLE_NUM(PN)) dut (
    .clock(clock), .rst(rst), .start(start),
    .mem_address(mem_address), .mem_rden(mem_rden), .mem_q(mem_q),
    .out_pos(out_pos), .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .out_last(out_last), .particle_count(particle_count),
    .busy(busy), .done(done), .count_err(count_err)
  );

  logic [DW-1:0] got_pos [$];
  logic [AW-1:0] got_idx [$];
  logic          got_last [$];
  logic [AW-1:0] rd_addr [$];
  int done_cnt, reads_before_first, rden_after_done;
  bit timeout;

  function automatic int exp_count(input int raw);
    return (raw > PN - 1) ? PN - 1 : raw;
  endfunction

  task automatic load_cell(input int raw);
    for (int i = 1; i < 256; i++) mem[i] = {$urandom, $urandom, $urandom};
    mem[0] = {$urandom, $urandom, $urandom};
    mem[0][AW-1:0] = AW'(raw);
  endtask

  function automatic logic ready_val(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (mode == 1) return c >= 20;
    return 1'($urandom_range(0, 1));
  endfunction

  // Reference comparison: particles 1..n in order, index k, last only on n, reads 1..n once each.
  function automatic int stream_mismatches(input int n);
    int bad = 0;
    if (got_pos.size() != n) bad++;
    for (int k = 0; k < got_pos.size(); k++)
      if (got_idx[k] !== AW'(k + 1) || got_pos[k] !== mem[k + 1] || got_last[k] !== (k + 1 == n)) bad++;
    if (rd_addr.size() != n) bad++;
    for (int k = 0; k < rd_addr.size(); k++)
      if (rd_addr[k] !== AW'(k + 1)) bad++;
    return bad;
  endfunction

  task automatic run_stream(input int mode, input bit restart_on_done);
    int  done_c = -1;
    got_pos.delete(); got_idx.delete(); got_last.delete(); rd_addr.delete();
    done_cnt = 0; reads_before_first = -1; rden_after_done = 0; timeout = 1'b0;
    @(posedge clock); #1;
    start = 1'b1;
    out_ready = ready_val(mode, 0);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      if (mem_rden && c != 1) begin
        rd_addr.push_back(mem_address);
        if (done_c >= 0) rden_after_done++;
      end
      if (out_valid && out_ready) begin
        if (got_pos.size() == 0) reads_before_first = rd_addr.size();
        got_pos.push_back(out_pos); got_idx.push_back(out_index); got_last.push_back(out_last);
      end
      if (done) begin
        done_cnt++;
        if (done_c < 0) done_c = c;
        if (restart_on_done) start = 1'b1;
      end
      @(posedge clock); #1;
      start = (mode == 2 && done_c < 0 && c >= 1) ? ($urandom_range(0, 7) == 0) : 1'b0;
      out_ready = ready_val(mode, c + 1);
      if (done_c >= 0 && c >= done_c + 4) break;
    end
    start = 1'b0;
    if (done_c < 0) timeout = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({mem_address, mem_rden, out_pos, out_valid, out_index, out_last, particle_count, busy, done, count_err} !== '0)
      begin errors++; $display("FAIL reset_outputs: got nonzero output vector, required all 0"); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    @(posedge clock); #1 rst = 1'b0;
  endtask

  task automatic test_basic;
    logic [2*AW+2:0] obs, exp;
    int  dcount = 0, dcyc = -1;
    load_cell(3);
    out_ready = 1'b1;
    @(posedge clock); #1 start = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clock);
      obs = {mem_rden, mem_rden ? mem_address : AW'(0), out_valid, out_valid ? out_index : AW'(0), out_last};
      exp = {(c == 1 || (c >= 4 && c <= 6)), (c >= 4 && c <= 6) ? AW'(c - 3) : AW'(0),
             (c >= 7 && c <= 9), (c >= 7 && c <= 9) ? AW'(c - 6) : AW'(0), (c == 9)};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL basic_cycle%0d: got %h required %h", c, obs, exp); end
      if (c >= 7 && c <= 9) begin
        checks++;
        if (out_pos !== mem[c - 6]) begin errors++; $display("FAIL basic_pos%0d: got %h required %h", c - 6, out_pos, mem[c - 6]); end
      end
      if (done) begin dcount++; dcyc = c; end
      @(posedge clock); #1 start = 1'b0;
    end
    checks++;
    if (dcount != 1 || (dcyc != 10 && dcyc != 11))
      begin errors++; $display("FAIL basic_done: got %0d pulses at cycle %0d required 1 at 10 or 11", dcount, dcyc); end
    checks++;
    if (particle_count !== AW'(3) || busy !== 1'b0)
      begin errors++; $display("FAIL basic_count: got count=%0d busy=%b required 3/0", particle_count, busy); end
  endtask

  task automatic test_zero;
    load_cell(0);
    run_stream(0, 1'b0);
    checks++;
    if (timeout || got_pos.size() != 0 || rd_addr.size() != 0)
      begin errors++; $display("FAIL zero_stream: got %0d outputs %0d reads timeout=%b required 0/0/0", got_pos.size(), rd_addr.size(), timeout); end
    checks++;
    if (done_cnt != 1 || busy !== 1'b0 || particle_count !== '0)
      begin errors++; $display("FAIL zero_done: got done=%0d busy=%b count=%0d required 1/0/0", done_cnt, busy, particle_count); end
  endtask

  task automatic test_one;
    load_cell(1);
    run_stream(0, 1'b0);
    checks++;
    if (timeout || stream_mismatches(1) != 0 || done_cnt != 1)
      begin errors++; $display("FAIL one_stream: got %0d mismatches done=%0d required 0/1", stream_mismatches(1), done_cnt); end
  endtask

  task automatic test_backpressure;
    load_cell(10);
    run_stream(1, 1'b0);
    checks++;
    if (timeout || stream_mismatches(10) != 0)
      begin errors++; $display("FAIL bp_stream: got %0d mismatches timeout=%b required 0", stream_mismatches(10), timeout); end
    checks++;
    if (reads_before_first != 4)
      begin errors++; $display("FAIL bp_outstanding: got %0d reads before first transfer required 4", reads_before_first); end
  endtask

  task automatic test_clamp;
    load_cell(255);
    run_stream(0, 1'b0);
    checks++;
    if (count_err !== 1'b1 || particle_count !== AW'(PN - 1))
      begin errors++; $display("FAIL clamp_flag: got err=%b count=%0d required 1/%0d", count_err, particle_count, PN - 1); end
    checks++;
    if (timeout || stream_mismatches(exp_count(255)) != 0)
      begin errors++; $display("FAIL clamp_stream: got %0d mismatches of %0d transfers required 0", stream_mismatches(exp_count(255)), got_pos.size()); end
    repeat (5) @(posedge clock);
    #1;
    checks++;
    if (count_err !== 1'b1) begin errors++; $display("FAIL clamp_sticky: got %b required 1", count_err); end
  endtask

  task automatic test_err_clear;
    load_cell(5);
    run_stream(2, 1'b0);
    checks++;
    if (count_err !== 1'b0 || particle_count !== AW'(5))
      begin errors++; $display("FAIL errclr_flag: got err=%b count=%0d required 0/5", count_err, particle_count); end
    checks++;
    if (timeout || stream_mismatches(5) != 0 || done_cnt != 1)
      begin errors++; $display("FAIL errclr_stream: got %0d mismatches done=%0d required 0/1", stream_mismatches(5), done_cnt); end
  endtask

  task automatic test_reset_midstream;
    int bad = 0;
    load_cell(10);
    out_ready = 1'b1;
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    rst = 1'b1;
    #1;
    checks++;
    if ({mem_address, mem_rden, out_pos, out_valid, out_index, out_last, particle_count, busy, done, count_err} !== '0)
      begin errors++; $display("FAIL midrst_outputs: got nonzero output vector, required all 0"); end
    @(posedge clock); @(posedge clock); #1 rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (out_valid || mem_rden || busy) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL midrst_quiet: got %0d active cycles required 0", bad); end
    load_cell(10);
    run_stream(0, 1'b0);
    checks++;
    if (timeout || stream_mismatches(10) != 0)
      begin errors++; $display("FAIL midrst_restart: got %0d mismatches required 0", stream_mismatches(10)); end
  endtask

  task automatic test_start_during_done;
    load_cell(4);
    run_stream(0, 1'b1);
    checks++;
    if (timeout || stream_mismatches(4) != 0)
      begin errors++; $display("FAIL sdone_stream: got %0d mismatches required 0", stream_mismatches(4)); end
    checks++;
    if (busy !== 1'b0 || rden_after_done != 0 || done_cnt != 1)
      begin errors++; $display("FAIL sdone_ignored: got busy=%b reads=%0d done=%0d required 0/0/1", busy, rden_after_done, done_cnt); end
  endtask

  task automatic test_random;
    load_cell(PN - 1);
    run_stream(2, 1'b0);
    checks++;
    if (timeout || stream_mismatches(PN - 1) != 0)
      begin errors++; $display("FAIL random_stream: got %0d mismatches of %0d transfers required 0", stream_mismatches(PN - 1), got_pos.size()); end
    checks++;
    if (count_err !== 1'b0 || particle_count !== AW'(PN - 1) || done_cnt != 1)
      begin errors++; $display("FAIL random_status: got err=%b count=%0d done=%0d required 0/%0d/1", count_err, particle_count, done_cnt, PN - 1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_one();
    test_backpressure();
    test_clamp();
    test_err_clear();
    test_reset_midstream();
    test_start_during_done();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
